// File: rtl/core_fetch_aligner_if.sv
// Fetch aligner bus bundle: instruction memory port, core-side
// instruction port and redirect inputs.
interface core_fetch_aligner_if #(
  parameter int XLEN = 32
);
  logic            mem_req_o;
  logic [XLEN-1:0] mem_addr_o;
  logic            mem_gnt_i;
  logic            mem_rvalid_i;
  logic [XLEN-1:0] mem_rdata_i;
  logic            instr_valid_o;
  logic [31:0]     instr_o;
  logic [XLEN-1:0] instr_pc_o;
  logic            instr_compressed_o;
  logic            instr_ready_i;
  logic            flush_i;
  logic [XLEN-1:0] flush_pc_i;

  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_gnt_i,
    input  mem_rvalid_i,
    input  mem_rdata_i,
    output instr_valid_o,
    output instr_o,
    output instr_pc_o,
    output instr_compressed_o,
    input  instr_ready_i,
    input  flush_i,
    input  flush_pc_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_gnt_i,
    output mem_rvalid_i,
    output mem_rdata_i,
    input  instr_valid_o,
    input  instr_o,
    input  instr_pc_o,
    input  instr_compressed_o,
    output instr_ready_i,
    output flush_i,
    output flush_pc_i
  );
endinterface

// File: rtl/core_fetch_aligner.sv
// Prefetch queue with RVC realignment: fetches words ahead of the
// core and emits whole 16b/32b instructions with their PC.
module core_fetch_aligner #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h1000_0000,
  parameter bit              RVC      = 1'b1
) (
  input logic              clk_i,
  input logic              rst_i,
  core_fetch_aligner_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 2;

  logic [XLEN-1:0] fifo_q [DEPTH];
  logic [XLEN-1:0] fifo_d [DEPTH];
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic [AW-1:0]   head_nx;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   disc_q, disc_d;
  logic [XLEN-1:0] fetch_q, fetch_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            off_q, off_d;

  logic [XLEN-1:0] hw;
  logic [15:0]     nlo;
  logic [31:0]     instr;
  logic            is32;
  logic            avail;
  logic            valid;
  logic            fire;
  logic            pop;
  logic            push;
  logic            drop;
  logic            req;
  logic            grant;
  logic [SW-1:0]   used;

  assign head_nx = head_q + AW'(1);
  assign hw      = fifo_q[head_q];
  assign nlo     = fifo_q[head_nx][15:0];

  // Decode the head instruction from the head word and hw offset
  always_comb begin
    is32  = 1'b1;
    instr = hw[31:0];
    avail = (count_q >= CW'(1));
    if (RVC) begin
      unique case ({off_q, off_q ? (hw[17:16] == 2'b11)
                                 : (hw[1:0] == 2'b11)})
        2'b00: begin
          is32  = 1'b0;
          instr = {16'h0, hw[15:0]};
        end
        2'b01: begin
          is32  = 1'b1;
          instr = hw[31:0];
        end
        2'b10: begin
          is32  = 1'b0;
          instr = {16'h0, hw[31:16]};
        end
        2'b11: begin
          is32  = 1'b1;
          instr = {nlo, hw[31:16]};
          avail = (count_q >= CW'(2));
        end
      endcase
    end
  end

  assign used  = SW'(count_q) + SW'(outst_q) + SW'(disc_q);
  assign req   = !rst_i && !bus.flush_i && (used < SW'(DEPTH));
  assign grant = req && bus.mem_gnt_i;
  assign valid = !rst_i && !bus.flush_i && avail;
  assign fire  = valid && bus.instr_ready_i;
  assign pop   = fire && (is32 || off_q);
  assign push  = bus.mem_rvalid_i && !bus.flush_i
                 && (disc_q == '0);
  assign drop  = bus.mem_rvalid_i && !bus.flush_i
                 && (disc_q != '0);

  assign bus.mem_req_o          = req;
  assign bus.mem_addr_o         = fetch_q;
  assign bus.instr_valid_o      = valid;
  assign bus.instr_o            = valid ? instr : 32'h0;
  assign bus.instr_pc_o         = valid ? pc_q : '0;
  assign bus.instr_compressed_o = valid && !is32;

  // Next-state: flush overrides push, pop, grant and consume
  always_comb begin
    fifo_d  = fifo_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    outst_d = outst_q;
    disc_d  = disc_q;
    fetch_d = fetch_q;
    pc_d    = pc_q;
    off_d   = off_q;
    if (bus.flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      outst_d = '0;
      disc_d  = disc_q + outst_q + CW'(grant)
                - CW'(bus.mem_rvalid_i);
      fetch_d = bus.flush_pc_i & ~XLEN'(3);
      if (RVC) begin
        off_d = bus.flush_pc_i[1];
        pc_d  = bus.flush_pc_i & ~XLEN'(1);
      end else begin
        off_d = 1'b0;
        pc_d  = bus.flush_pc_i & ~XLEN'(3);
      end
    end else begin
      if (push) begin
        fifo_d[tail_q] = bus.mem_rdata_i;
        tail_d         = tail_q + AW'(1);
      end
      if (pop) begin
        head_d = head_nx;
      end
      count_d = count_q + CW'(push) - CW'(pop);
      outst_d = outst_q + CW'(grant) - CW'(push);
      if (drop) begin
        disc_d = disc_q - CW'(1);
      end
      if (grant) begin
        fetch_d = fetch_q + XLEN'(4);
      end
      if (fire) begin
        pc_d = pc_q + (is32 ? XLEN'(4) : XLEN'(2));
        if (RVC && !is32) begin
          off_d = !off_q;
        end
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      outst_q <= '0;
      disc_q  <= '0;
      fetch_q <= RESET_PC;
      pc_q    <= RESET_PC;
      off_q   <= 1'b0;
    end else begin
      fifo_q  <= fifo_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      outst_q <= outst_d;
      disc_q  <= disc_d;
      fetch_q <= fetch_d;
      pc_q    <= pc_d;
      off_q   <= off_d;
    end
  end

endmodule
